// File: rtl/phase_measure_ctrl.sv
// phase_measure_ctrl
//   Measurement sequencer for the start/stop phase detector (clk_sample domain).
//   It holds the detector in reset while idle. On start it flushes the detector
//   and drops the first (partial) tag. It then accumulates sum/count/min/max
//   over the requested number of tags, flags start_count gaps and per-tag
//   timeouts, and presents one result record to the host.
//
//   Optional feature macro: PHASE_MEAS_MINMAX_EN
//     defined   : result_min/result_max track the extrema of accepted tags
//     undefined : min/max registers are absent, result_min/result_max read 0
//
// Ports
//   clk_sample, rst_n          clock, asynchronous active-low reset
//   start, num_samples,        measurement request; num_samples and
//   timeout_cycles             timeout_cycles are sampled with start
//   busy, det_rst              sequencer busy, active-high detector reset
//   tag_in, start_count_in,    detector phase tag, clk_0 sequence count and
//   tag_valid_in               tag strobe
//   result_sum, result_count,  result record (registered, held stable while
//   result_min, result_max,    result_valid is high)
//   err_timeout, err_skip
//   result_valid, result_ready result handshake
//   dbg_state                  current FSM state encoding, for observation
//
// Result handshake: result_valid rises with a complete record and stays high,
// with every result field frozen, until the host drives result_ready on a
// cycle where result_valid is high. The record transfers on that edge and
// result_valid drops from the same edge.
module phase_measure_ctrl #(
  parameter int PHASE_COUNT_SIZE = 5,
  parameter int CLK_0_COUNT_SIZE = 3,
  parameter int NUM_SAMPLES_SIZE = 8,
  parameter int TIMEOUT_SIZE     = 12,
  parameter int FLUSH_CYCLES     = 4
) (
  input  logic                                     clk_sample,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [NUM_SAMPLES_SIZE-1:0]              num_samples,
  input  logic [TIMEOUT_SIZE-1:0]                  timeout_cycles,
  output logic                                     busy,
  output logic                                     det_rst,
  input  logic [PHASE_COUNT_SIZE-1:0]              tag_in,
  input  logic [CLK_0_COUNT_SIZE-1:0]              start_count_in,
  input  logic                                     tag_valid_in,
  output logic [PHASE_COUNT_SIZE+NUM_SAMPLES_SIZE-1:0] result_sum,
  output logic [NUM_SAMPLES_SIZE-1:0]              result_count,
  output logic [PHASE_COUNT_SIZE-1:0]              result_min,
  output logic [PHASE_COUNT_SIZE-1:0]              result_max,
  output logic                                     err_timeout,
  output logic                                     err_skip,
  output logic                                     result_valid,
  input  logic                                     result_ready,
  output logic [2:0]                               dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_DISCARD = 3'd2,
    S_ACCUM   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  state_t                      state;
  logic [NUM_SAMPLES_SIZE-1:0] num_lat;
  logic [TIMEOUT_SIZE-1:0]     tmo_lat;
  logic [TIMEOUT_SIZE-1:0]     tmo_cnt;
  logic [FW-1:0]               flush_cnt;
  logic [CLK_0_COUNT_SIZE-1:0] ref_count;

  logic [NUM_SAMPLES_SIZE-1:0] count_next;
  logic [TIMEOUT_SIZE-1:0]     tmo_next;
  logic [CLK_0_COUNT_SIZE-1:0] ref_next;
  logic                        launch;
  logic                        accept;
  logic                        timeout_fire;

  assign count_next = result_count + 1'b1;
  assign tmo_next   = tmo_cnt + 1'b1;
  assign ref_next   = ref_count + 1'b1;
  assign launch     = (state == S_IDLE) && start;
  assign accept     = (state == S_ACCUM) && tag_valid_in;
  // A tag on the same edge wins over the timeout, hence the !tag_valid_in term.
  assign timeout_fire = ((state == S_DISCARD) || (state == S_ACCUM)) && !tag_valid_in &&
                        (tmo_lat != '0) && (tmo_next == tmo_lat);
  assign dbg_state  = state;

  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      det_rst      <= 1'b1;
      result_valid <= 1'b0;
      result_sum   <= '0;
      result_count <= '0;
      err_timeout  <= 1'b0;
      err_skip     <= 1'b0;
      num_lat      <= '0;
      tmo_lat      <= '0;
      tmo_cnt      <= '0;
      flush_cnt    <= '0;
      ref_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            num_lat      <= num_samples;
            tmo_lat      <= timeout_cycles;
            result_sum   <= '0;
            result_count <= '0;
            err_timeout  <= 1'b0;
            err_skip     <= 1'b0;
            flush_cnt    <= '0;
            busy         <= 1'b1;
            if (num_samples == '0) begin
              state        <= S_DONE;
              result_valid <= 1'b1;
            end else begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state   <= S_DISCARD;
            det_rst <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        S_DISCARD: begin
          if (tag_valid_in) begin
            // First tag after flush straddles the reset release: keep only its count.
            ref_count <= start_count_in;
            tmo_cnt   <= '0;
            state     <= S_ACCUM;
          end else if (timeout_fire) begin
            err_timeout  <= 1'b1;
            det_rst      <= 1'b1;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            result_sum   <= result_sum + {{NUM_SAMPLES_SIZE{1'b0}}, tag_in};
            result_count <= count_next;
            ref_count    <= start_count_in;
            tmo_cnt      <= '0;
            if (start_count_in != ref_next) err_skip <= 1'b1;
            if (count_next == num_lat) begin
              det_rst      <= 1'b1;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end
          end else if (timeout_fire) begin
            err_timeout  <= 1'b1;
            det_rst      <= 1'b1;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PHASE_MEAS_MINMAX_EN
  logic [PHASE_COUNT_SIZE-1:0] min_r;
  logic [PHASE_COUNT_SIZE-1:0] max_r;

  // min starts at all-ones so the first tag always replaces it; a measurement
  // that ends with no accepted tag forces it back to 0.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      min_r <= '0;
      max_r <= '0;
    end else if (launch) begin
      min_r <= (num_samples == '0) ? '0 : '1;
      max_r <= '0;
    end else if (accept) begin
      if (tag_in < min_r) min_r <= tag_in;
      if (tag_in > max_r) max_r <= tag_in;
    end else if (timeout_fire && (result_count == '0)) begin
      min_r <= '0;
    end
  end

  assign result_min = min_r;
  assign result_max = max_r;
`else
  assign result_min = '0;
  assign result_max = '0;
`endif

endmodule

// File: tb/tb_phase_measure_ctrl.sv
// tb_phase_measure_ctrl
//   Self-checking bench for phase_measure_ctrl. Inputs are driven on the
//   falling edge and outputs observed one falling edge later. The reference
//   model works from the measurement rules: it records every tag that should
//   be accepted in exp_q, counts cycles since the last tag to predict the
//   timeout, and derives sum/count/min/max/error flags from that queue.
module tb_phase_measure_ctrl;
  localparam int PW = 5;
  localparam int CW = 3;
  localparam int NW = 8;
  localparam int TW = 12;
  localparam int FC = 4;

  logic              clk_sample = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NW-1:0]     num_samples = '0;
  logic [TW-1:0]     timeout_cycles = '0;
  logic              busy;
  logic              det_rst;
  logic [PW-1:0]     tag_in = '0;
  logic [CW-1:0]     start_count_in = '0;
  logic              tag_valid_in = 1'b0;
  logic [PW+NW-1:0]  result_sum;
  logic [NW-1:0]     result_count;
  logic [PW-1:0]     result_min;
  logic [PW-1:0]     result_max;
  logic              err_timeout;
  logic              err_skip;
  logic              result_valid;
  logic              result_ready = 1'b0;
  logic [2:0]        dbg_state;

  phase_measure_ctrl #(
    .PHASE_COUNT_SIZE(PW), .CLK_0_COUNT_SIZE(CW), .NUM_SAMPLES_SIZE(NW),
    .TIMEOUT_SIZE(TW), .FLUSH_CYCLES(FC)
  ) dut (
    .clk_sample(clk_sample), .rst_n(rst_n), .start(start),
    .num_samples(num_samples), .timeout_cycles(timeout_cycles),
    .busy(busy), .det_rst(det_rst), .tag_in(tag_in),
    .start_count_in(start_count_in), .tag_valid_in(tag_valid_in),
    .result_sum(result_sum), .result_count(result_count),
    .result_min(result_min), .result_max(result_max),
    .err_timeout(err_timeout), .err_skip(err_skip),
    .result_valid(result_valid), .result_ready(result_ready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_sample = ~clk_sample;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int gap;
    int tag;
    int sc;
  } ev_t;

  ev_t             dir_q[$];
  logic [PW-1:0]   exp_q[$];
  bit              exp_skip;
  bit              exp_tmo;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sample);
    @(negedge clk_sample);
  endtask

  // Scoreboard: expected record derived from the accepted-tag queue.
  task automatic check_result(input string name);
    longint s;
    int mn;
    int mx;
    s  = 0;
    mn = 0;
    mx = 0;
    if (exp_q.size() > 0) begin
      mn = 31;
      foreach (exp_q[i]) begin
        s += exp_q[i];
        if (exp_q[i] < mn) mn = exp_q[i];
        if (exp_q[i] > mx) mx = exp_q[i];
      end
    end
`ifndef PHASE_MEAS_MINMAX_EN
    mn = 0;
    mx = 0;
`endif
    check({name, "_sum"},   result_sum,   s);
    check({name, "_count"}, result_count, exp_q.size());
    check({name, "_min"},   result_min,   mn);
    check({name, "_max"},   result_max,   mx);
    check({name, "_etmo"},  err_timeout,  exp_tmo);
    check({name, "_eskip"}, err_skip,     exp_skip);
    check({name, "_busy"},  busy,         1);
    check({name, "_drst"},  det_rst,      1);
  endtask

  function automatic int next_gap(input bit use_dir, input int gap_max);
    if (use_dir) return (dir_q.size() > 0) ? dir_q[0].gap : 0;
    return $urandom_range(0, gap_max);
  endfunction

  // One complete measurement, including flush checks, per-cycle timing
  // prediction, backpressure of `hold` cycles and the handshake.
  task automatic measure(input int n, input int tmo, input int n_tags, input bit skip_en,
                         input int gap_max, input bit use_dir, input int hold);
    int  since;
    int  idle_left;
    int  sent;
    int  ref_sc;
    int  sc;
    int  tg;
    int  cyc;
    bit  discarded;
    bit  done;
    bit  drive;
    exp_q.delete();
    exp_skip = 1'b0;
    exp_tmo  = 1'b0;
    num_samples    = NW'(n);
    timeout_cycles = TW'(tmo);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (n == 0) begin
      check("rv_zero", result_valid, 1);
      check_result("zero");
    end else begin
      check("drst_start", det_rst, 1);
      check("rv_start", result_valid, 0);
      // Tags during the flush window must be ignored.
      for (int i = 1; i <= FC; i++) begin
        tag_valid_in   = 1'($urandom_range(0, 1));
        tag_in         = PW'($urandom);
        start_count_in = CW'($urandom);
        tick();
        check((i < FC) ? "drst_flush" : "drst_fall", det_rst, (i < FC) ? 1 : 0);
      end
      tag_valid_in = 1'b0;
      since = 0; discarded = 0; done = 0; sent = 0; ref_sc = 0; cyc = 0; tg = 0;
      sc = $urandom_range(0, 7);
      idle_left = next_gap(use_dir, gap_max);
      while (!done && cyc < 3000) begin
        drive = 1'b0;
        if (idle_left == 0) begin
          if (use_dir) begin
            if (dir_q.size() > 0) begin
              drive = 1'b1;
              tg = dir_q[0].tag;
              sc = dir_q[0].sc;
              void'(dir_q.pop_front());
            end
          end else if (sent < n_tags + 1) begin
            drive = 1'b1;
            tg = $urandom_range(0, 31);
            if (sent > 0) sc = (sc + ((skip_en && $urandom_range(0, 3) == 0) ? 2 : 1)) % 8;
          end
        end
        if (drive) idle_left = next_gap(use_dir, gap_max);
        else if (idle_left > 0) idle_left--;
        tag_valid_in   = drive;
        tag_in         = PW'(tg);
        start_count_in = CW'(sc);
        tick();
        cyc++;
        since++;
        if (drive) begin
          sent++;
          if (!discarded) begin
            discarded = 1'b1;
          end else begin
            exp_q.push_back(PW'(tg));
            if (((sc - ref_sc) & 7) != 1) exp_skip = 1'b1;
            if (exp_q.size() == n) done = 1'b1;
          end
          ref_sc = sc;
          since  = 0;
        end else if (tmo != 0 && since == tmo) begin
          exp_tmo = 1'b1;
          done    = 1'b1;
        end
        if (!done) begin
          check("rv_low", result_valid, 0);
          check("drst_low", det_rst, 0);
        end
      end
      tag_valid_in = 1'b0;
      check("rv_done", result_valid, 1);
      check_result("done");
    end
    // Backpressure: record must stay put; start pulses are ignored.
    for (int i = 0; i < hold; i++) begin
      result_ready = 1'b0;
      start        = 1'($urandom_range(0, 1));
      num_samples  = NW'($urandom);
      tick();
      check("rv_hold", result_valid, 1);
      check_result("hold");
    end
    start        = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("rv_clear", result_valid, 0);
    check("busy_clear", busy, 0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_busy"},  busy,         0);
    check({name, "_drst"},  det_rst,      1);
    check({name, "_rv"},    result_valid, 0);
    check({name, "_sum"},   result_sum,   0);
    check({name, "_count"}, result_count, 0);
    check({name, "_min"},   result_min,   0);
    check({name, "_max"},   result_max,   0);
    check({name, "_etmo"},  err_timeout,  0);
    check({name, "_eskip"}, err_skip,     0);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
    check_reset_values("idle");

    // basic: discard tag, then 3,5,7,9 with start_count 1..4
    dir_q = '{'{2, 20, 0}, '{0, 3, 1}, '{1, 5, 2}, '{3, 7, 3}, '{0, 9, 4}};
    measure(4, 0, 0, 0, 0, 1, 5);

    // skip: start_count 1,2,4
    dir_q = '{'{1, 4, 0}, '{0, 10, 1}, '{0, 11, 2}, '{0, 12, 4}};
    measure(3, 0, 0, 0, 0, 1, 2);

    // timeout after two tags
    dir_q = '{'{0, 1, 6}, '{3, 17, 7}, '{2, 22, 0}};
    measure(8, 20, 0, 0, 0, 1, 1);

    // tag landing on the timeout edge is accepted (discard and accumulate)
    dir_q = '{'{4, 1, 5}, '{4, 6, 6}, '{4, 2, 7}, '{4, 30, 0}};
    measure(3, 5, 0, 0, 0, 1, 0);

    // timeout with no accepted tag, in accumulate and in discard
    dir_q = '{'{1, 8, 3}};
    measure(5, 8, 0, 0, 0, 1, 1);
    dir_q.delete();
    measure(5, 6, 0, 0, 0, 1, 0);

    // zero samples with 10 cycles of backpressure
    measure(0, 0, 0, 0, 0, 1, 10);

    // async reset in the middle of accumulation
    num_samples    = 8'd10;
    timeout_cycles = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (FC) tick();
    for (int k = 0; k < 4; k++) begin
      tag_valid_in   = 1'b1;
      tag_in         = PW'(k + 1);
      start_count_in = CW'(k);
      tick();
    end
    tag_valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk_sample);
    rst_n = 1'b1;
    tick();
    check_reset_values("post_rst");
    measure(4, 0, 4, 0, 3, 0, 1);

    // randomized measurements
    for (int it = 0; it < 25; it++) begin
      int n;
      int tmo;
      int nt;
      n   = $urandom_range(1, 12);
      tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 15);
      nt  = (tmo != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n) : n;
      measure(n, tmo, nt, 1'($urandom_range(0, 1)), $urandom_range(0, 6), 0,
              $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
